// File: rtl/bus_seq_pkg.sv
// Shared types and constants for the bus master sequencer.
// Consumed by bus_seq_timer and bus_master_seq.
package bus_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_TURN,
    S_READ,
    S_RESP
  } state_e;

  localparam logic RNW_READ  = 1'b1;
  localparam logic RNW_WRITE = 1'b0;

  localparam int DW_DEF         = 8;
  localparam int TURN_CYC_DEF   = 1;
  localparam int SAMPLE_DLY_DEF = 1;

  localparam int TURN_MIN   = 0;
  localparam int TURN_MAX   = 3;
  localparam int SAMPLE_MIN = 1;
  localparam int SAMPLE_MAX = 4;

  localparam int CNT_W = 2;

  // Timer counts down to zero, so a phase of N cycles loads N-1.
  function automatic logic [CNT_W-1:0] cnt_init(input int cycles);
    logic [CNT_W-1:0] v;
    v = CNT_W'(cycles - 1);
    return v;
  endfunction

endpackage

// File: rtl/bus_seq_timer.sv
// Loadable down-counter timing the TURN and READ phases.
// done_o is high while the count sits at zero.
import bus_seq_pkg::*;

module bus_seq_timer (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/bus_master_seq.sv
// Bus master sequencer for the output-register tile data bus.
// Define BUS_MASTER_SEQ_VERIFY_EN to add a readback phase after writes.
import bus_seq_pkg::*;

module bus_master_seq #(
  parameter int DW         = DW_DEF,
  parameter int TURN_CYC   = TURN_CYC_DEF,
  parameter int SAMPLE_DLY = SAMPLE_DLY_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          bus_rnw,
  output logic [DW-1:0] bus_dout,
  output logic [DW-1:0] bus_oe,
  input  logic [DW-1:0] bus_din,
  output logic          busy
);

  if (TURN_CYC < TURN_MIN || TURN_CYC > TURN_MAX ||
      SAMPLE_DLY < SAMPLE_MIN ||
      SAMPLE_DLY > SAMPLE_MAX) begin : g_bad_param
    $error("bus_master_seq: TURN_CYC/SAMPLE_DLY out of range");
  end

`ifdef BUS_MASTER_SEQ_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  localparam bit HAS_TURN = (TURN_CYC > 0);

  state_e           state_q;
  logic             rnw_q;
  logic [DW-1:0]    oe_q;
  logic [DW-1:0]    dout_q;
  logic [DW-1:0]    data_q;
  logic             rsp_valid_q;
  logic [DW-1:0]    rsp_data_q;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;
  logic             accept;

  assign accept = cmd_valid && (state_q == S_IDLE);

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (accept && !cmd_write) begin
          tmr_load = 1'b1;
          tmr_val  = cnt_init(SAMPLE_DLY);
        end
      end
      S_WRITE: begin
        if (HAS_TURN) begin
          tmr_load = 1'b1;
          tmr_val  = cnt_init(TURN_CYC);
        end else if (VERIFY) begin
          tmr_load = 1'b1;
          tmr_val  = cnt_init(SAMPLE_DLY);
        end
      end
      S_TURN: begin
        if (tmr_done && VERIFY) begin
          tmr_load = 1'b1;
          tmr_val  = cnt_init(SAMPLE_DLY);
        end
      end
      default: ;
    endcase
  end

  bus_seq_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

`ifdef BUS_MASTER_SEQ_VERIFY_EN
  logic write_q;
  logic err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rnw_q       <= RNW_READ;
      oe_q        <= '0;
      dout_q      <= '0;
      data_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef BUS_MASTER_SEQ_VERIFY_EN
      write_q     <= 1'b0;
      err_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            data_q <= cmd_data;
`ifdef BUS_MASTER_SEQ_VERIFY_EN
            write_q <= cmd_write;
`endif
            if (cmd_write) begin
              state_q <= S_WRITE;
              rnw_q   <= RNW_WRITE;
              oe_q    <= '1;
              dout_q  <= cmd_data;
            end else begin
              state_q <= S_READ;
            end
          end
        end
        S_WRITE: begin
          // Release the bus on the same edge the target captures.
          rnw_q <= RNW_READ;
          oe_q  <= '0;
          if (HAS_TURN) begin
            state_q <= S_TURN;
          end else if (VERIFY) begin
            state_q <= S_READ;
          end else begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= data_q;
          end
        end
        S_TURN: begin
          if (tmr_done) begin
            if (VERIFY) begin
              state_q <= S_READ;
            end else begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= data_q;
            end
          end
        end
        S_READ: begin
          if (tmr_done) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= bus_din;
`ifdef BUS_MASTER_SEQ_VERIFY_EN
            err_q <= write_q && (bus_din != data_q);
`endif
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign bus_rnw   = rnw_q;
  assign bus_oe    = oe_q;
  assign bus_dout  = dout_q;

`ifdef BUS_MASTER_SEQ_VERIFY_EN
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_master_seq.sv
// Directed bench for bus_master_seq with a target register model.
// Runs in both the default and BUS_MASTER_SEQ_VERIFY_EN builds.
module tb_bus_master_seq;

`ifdef BUS_MASTER_SEQ_VERIFY_EN
  localparam int WLAT = 5;
`else
  localparam int WLAT = 3;
`endif
  localparam int RLAT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       bus_rnw;
  logic [7:0] bus_dout;
  logic [7:0] bus_oe;
  logic [7:0] bus_din;
  logic       busy;

  logic [7:0] tgt;
  logic [7:0] stuck = 8'h00;
  logic [7:0] ref_reg;
  logic [7:0] wdat = 8'h00;
  int         nchk = 0;
  int         nfail = 0;
  int         viol = 0;
  int         wcyc = 0;

  always #5 clk = ~clk;

  bus_master_seq #(
    .DW         (8),
    .TURN_CYC   (1),
    .SAMPLE_DLY (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .bus_rnw   (bus_rnw),
    .bus_dout  (bus_dout),
    .bus_oe    (bus_oe),
    .bus_din   (bus_din),
    .busy      (busy)
  );

  // Target: captures while R_nW=0, drives the bus while R_nW=1.
  always @(posedge clk)
    if (bus_rnw == 1'b0) tgt <= (bus_dout & bus_oe) | stuck;

  assign bus_din = bus_rnw ? tgt : (bus_dout & bus_oe);

  always @(negedge clk) begin
    if (rst_n) begin
      if ((bus_rnw === 1'b1 && bus_oe !== 8'h00) ||
          (bus_rnw === 1'b0 && bus_oe !== 8'hFF))
        viol++;
      if (bus_rnw === 1'b0) begin
        wcyc++;
        wdat = bus_dout;
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input bit wr, input logic [7:0] d,
                        input logic [7:0] exp_d, input bit exp_e,
                        input int exp_lat, input string tag);
    int lat;
    int w0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_data  = d;
    rsp_ready = 1'b1;
    check({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
    w0 = wcyc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (rsp_valid === 1'b1) break;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".rsp_data"}, 32'(rsp_data), 32'(exp_d));
    check({tag, ".rsp_err"}, 32'(rsp_err), 32'(exp_e));
    #1;
    check({tag, ".wr_cycles"}, 32'(wcyc - w0), wr ? 32'd1 : 32'd0);
    if (wr) check({tag, ".bus_dout"}, 32'(wdat), 32'(d));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int seen;
    bit wr;
    logic [7:0] d;

    #12;
    check("rst.bus_rnw", 32'(bus_rnw), 32'd1);
    check("rst.bus_oe", 32'(bus_oe), 32'd0);
    check("rst.bus_dout", 32'(bus_dout), 32'd0);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.rsp_data", 32'(rsp_data), 32'd0);
    check("rst.rsp_err", 32'(rsp_err), 32'd0);
    check("rst.cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst.busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_cmd(1'b1, 8'hA5, 8'hA5, 1'b0, WLAT, "wrA5");
    check("wrA5.target", 32'(tgt), 32'hA5);
    do_cmd(1'b1, 8'h3C, 8'h3C, 1'b0, WLAT, "wr3C");
    do_cmd(1'b0, 8'h00, 8'h3C, 1'b0, RLAT, "rd3C");

    stuck = 8'h01;
`ifdef BUS_MASTER_SEQ_VERIFY_EN
    do_cmd(1'b1, 8'h5A, 8'h5B, 1'b1, WLAT, "stuck");
`else
    do_cmd(1'b1, 8'h5A, 8'h5A, 1'b0, WLAT, "stuck");
`endif
    stuck = 8'h00;
    check("stuck.target", 32'(tgt), 32'h5B);

    // Backpressure: read held in RESP while the next command waits.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    rsp_ready = 1'b0;
    check("bp.accept", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_write = 1'b1;
    cmd_data  = 8'h77;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (rsp_valid === 1'b1) break;
    end
    check("bp.latency", 32'(lat), 32'(RLAT));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp.cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp.rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp.rsp_data", 32'(rsp_data), 32'h5B);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp.idle_ready", 32'(cmd_ready), 32'd1);
    check("bp.rsp_drop", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("bp.next_busy", 32'(busy), 32'd1);
    check("bp.next_rnw", 32'(bus_rnw), 32'd0);
    check("bp.next_dout", 32'(bus_dout), 32'h77);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (rsp_valid === 1'b1) break;
    end
    check("bp.next_latency", 32'(lat), 32'(WLAT));
    check("bp.next_data", 32'(rsp_data), 32'h77);
    @(posedge clk);
    #1;
    ref_reg = 8'h77;

    // Reset asserted during the write cycle.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_data  = 8'h99;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("rstw.oe_before", 32'(bus_oe), 32'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstw.bus_oe", 32'(bus_oe), 32'd0);
    check("rstw.bus_rnw", 32'(bus_rnw), 32'd1);
    check("rstw.busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen++;
    end
    check("rstw.no_rsp", 32'(seen), 32'd0);
    check("rstw.target", 32'(tgt), 32'(ref_reg));
    @(posedge clk);
    #1;

    for (int i = 0; i < 24; i++) begin
      wr = 1'($urandom_range(0, 1));
      d  = 8'($urandom_range(0, 255));
      if (wr) begin
        do_cmd(1'b1, d, d, 1'b0, WLAT, "rnd.wr");
        ref_reg = d;
      end else begin
        do_cmd(1'b0, d, ref_reg, 1'b0, RLAT, "rnd.rd");
      end
    end
    check("rnd.target", 32'(tgt), 32'(ref_reg));
    check("bus.contention", 32'(viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
